count_display: RTL and testbench

Display-side consumer of the up-counter's outputs: takes the 8-bit `count` and 2-bit `tcount` and drives a 4-digit common-anode multiplexed seven-segment display on the 100 MHz system clock. A sequential double-dabble FSM converts `count` to BCD (hundreds/tens/ones). A scan prescaler time-multiplexes the digits; digit 3 shows `tcount`. The block sits beside the counter in the top-level wrapper and takes the counter outputs directly.

---
 rtl/count_display.sv | 182 ++++++++++++++++++
 tb/tb_count_display.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/count_display.sv
// Four-digit multiplexed seven-segment driver for the up-counter outputs.
// A sequential double-dabble converter feeds hundreds/tens/ones; digit 3 shows tcount.
//
// state | meaning
// IDLE  | waiting for {tcount,count} to differ from the shown value
// CONV  | eight add-3/shift iterations of the double-dabble
// DONE  | copy BCD result and tcount into the display registers
module count_display #(
    parameter int CLK_HZ     = 100000000,
    parameter int REFRESH_HZ = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] count,
    input  logic [1:0] tcount,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    localparam int SCAN_DIV = CLK_HZ / (4 * REFRESH_HZ);
    localparam int PW       = $clog2(SCAN_DIV + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t        state_q, state_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [7:0]    bin_q, bin_d;
    logic [2:0]    iter_q, iter_d;
    logic [9:0]    shown_q, shown_d;
    logic [3:0]    hund_q, hund_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [1:0]    tdig_q, tdig_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic [3:0]    h_adj, t_adj, o_adj;
    logic [3:0]    digit_val;
    logic          digit_blank;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        bcd_d       = bcd_q;
        bin_d       = bin_q;
        iter_d      = iter_q;
        shown_d     = shown_q;
        hund_d      = hund_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        tdig_d      = tdig_q;
        presc_d     = presc_q;
        idx_d       = idx_q;
        digit_val   = 4'd0;
        digit_blank = 1'b0;

        h_adj = add3(bcd_q[11:8]);
        t_adj = add3(bcd_q[7:4]);
        o_adj = add3(bcd_q[3:0]);

        case (state_q)
            IDLE: begin
                if ({tcount, count} != shown_q) begin
                    shown_d = {tcount, count};
                    bin_d   = count;
                    bcd_d   = 12'd0;
                    iter_d  = 3'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                {bcd_d, bin_d} = {h_adj, t_adj, o_adj, bin_q} << 1;
                iter_d         = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                hund_d  = bcd_q[11:8];
                tens_d  = bcd_q[7:4];
                ones_d  = bcd_q[3:0];
                tdig_d  = shown_q[9:8];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Disabling parks the scan so re-enable always starts from the ones digit.
        if (!en) begin
            presc_d = '0;
            idx_d   = 2'd0;
        end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        case (idx_q)
            2'd0: digit_val = ones_q;
            2'd1: begin
                digit_val   = tens_q;
                digit_blank = (hund_q == 4'd0) && (tens_q == 4'd0);
            end
            2'd2: begin
                digit_val   = hund_q;
                digit_blank = (hund_q == 4'd0);
            end
            default: digit_val = {2'b00, tdig_q};
        endcase

        an_d  = en ? ~(4'b0001 << idx_q) : 4'b1111;
        seg_d = (!en || digit_blank) ? 7'h7F : seg_code(digit_val);
        dp_d  = !(en && (idx_q == 2'd3));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            bcd_q   <= 12'd0;
            bin_q   <= 8'd0;
            iter_q  <= 3'd0;
            shown_q <= 10'h000;
            hund_q  <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            tdig_q  <= 2'd0;
            presc_q <= '0;
            idx_q   <= 2'd0;
            an_q    <= 4'b1111;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            iter_q  <= iter_d;
            shown_q <= shown_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            tdig_q  <= tdig_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_count_display.sv
// Directed bench for count_display with a 10-cycle digit dwell.
module tb_count_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] count;
    logic [1:0] tcount;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    int n_checks = 0;
    int n_errs   = 0;

    count_display #(.CLK_HZ(400), .REFRESH_HZ(10)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .count  (count),
        .tcount (tcount),
        .an     (an),
        .seg    (seg),
        .dp     (dp),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full 40-cycle frame starting from the edge that first sees en=1 at digit 0.
    task automatic check_scan(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an;
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            exp_an = 4'b1111;
            exp_an[k / 10] = 1'b0;
            check({tag, "_an"},   16'(an),   16'(exp_an));
            check({tag, "_seg"},  16'(seg),  16'(exp_seg[k / 10]));
            check({tag, "_dp"},   16'(dp),   16'((k / 10) != 3));
            check({tag, "_busy"}, 16'(busy), 16'd0);
        end
    endtask

    task automatic expect_digit(input string tag, input logic [3:0] an_want, input logic [6:0] seg_exp);
        int n = 0;
        while (an !== an_want && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_an"},  16'(an),  16'(an_want));
        check({tag, "_seg"}, 16'(seg), 16'(seg_exp));
        check({tag, "_dp"},  16'(dp),  16'(an_want != 4'b0111));
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; count = 8'd0; tcount = 2'd0;

        // reset state, then first frame of zeros
        repeat (3) @(negedge clk);
        check("rst_an",   16'(an),   16'hF);
        check("rst_seg",  16'(seg),  16'h7F);
        check("rst_dp",   16'(dp),   16'd1);
        check("rst_busy", 16'(busy), 16'd0);
        rst = 1'b1;
        check_scan("zero", 7'h40, 7'h7F, 7'h7F, 7'h40);

        // 255 / tcount 2: busy exactly nine cycles after capture
        count = 8'd255; tcount = 2'd2;
        for (int j = 0; j < 11; j++) begin
            @(negedge clk);
            check("busy255", 16'(busy), 16'(j < 9));
        end
        expect_digit("d255_ones", 4'b1110, 7'h12);
        expect_digit("d255_tens", 4'b1101, 7'h12);
        expect_digit("d255_hund", 4'b1011, 7'h24);
        expect_digit("d255_tc",   4'b0111, 7'h24);

        // 7 / tcount 1: both leading zeros blanked
        count = 8'd7; tcount = 2'd1;
        repeat (12) @(negedge clk);
        expect_digit("d7_ones", 4'b1110, 7'h78);
        expect_digit("d7_tens", 4'b1101, 7'h7F);
        expect_digit("d7_hund", 4'b1011, 7'h7F);
        expect_digit("d7_tc",   4'b0111, 7'h79);

        // 105: embedded zero in tens is shown
        count = 8'd105;
        repeat (12) @(negedge clk);
        expect_digit("d105_ones", 4'b1110, 7'h12);
        expect_digit("d105_tens", 4'b1101, 7'h40);
        expect_digit("d105_hund", 4'b1011, 7'h79);

        // 200 then 42 mid-conversion: one idle cycle, then a second conversion
        count = 8'd200;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            check("busy_rechk", 16'(busy), 16'((j < 9) || (j >= 10)));
            if (j == 2) count = 8'd42;
        end
        repeat (12) @(negedge clk);
        check("busy42_done", 16'(busy), 16'd0);
        expect_digit("d42_ones", 4'b1110, 7'h24);
        expect_digit("d42_tens", 4'b1101, 7'h19);
        expect_digit("d42_hund", 4'b1011, 7'h7F);
        expect_digit("d42_tc",   4'b0111, 7'h79);

        // disable in the middle of digit 2, then re-enable
        expect_digit("pre_dis", 4'b1011, 7'h7F);
        repeat (4) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("dis_an",  16'(an),  16'hF);
        check("dis_seg", 16'(seg), 16'h7F);
        check("dis_dp",  16'(dp),  16'd1);
        repeat (3) @(negedge clk);
        check("dis_hold_an", 16'(an), 16'hF);
        en = 1'b1;
        check_scan("reen", 7'h24, 7'h19, 7'h7F, 7'h79);

        // reset during a conversion aborts it; the value is reconverted afterwards
        count = 8'd99;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 16'(busy), 16'd1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 16'(busy), 16'd0);
        check("midrst_an",   16'(an),   16'hF);
        check("midrst_seg",  16'(seg),  16'h7F);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check("d99_busy", 16'(busy), 16'd0);
        expect_digit("d99_ones", 4'b1110, 7'h10);
        expect_digit("d99_tens", 4'b1101, 7'h10);
        expect_digit("d99_hund", 4'b1011, 7'h7F);
        expect_digit("d99_tc",   4'b0111, 7'h79);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
